// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID-stage read-port bundle for wb_regfile.
// The pipeline drives through the master modport; the register file uses slave.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [1:0]        MemtoReg_i;
  logic              RegWr_i;
  logic [ADDR_W-1:0] WriteAddr_i;
  logic [DATA_W-1:0] ALUOut_i;
  logic [DATA_W-1:0] MemData_i;
  logic [DATA_W-1:0] PCPlus4_i;
  logic [ADDR_W-1:0] RsAddr_i;
  logic [ADDR_W-1:0] RtAddr_i;
  logic [DATA_W-1:0] RsData_o;
  logic [DATA_W-1:0] RtData_o;
  logic [DATA_W-1:0] WbData_o;
  logic              WbEn_o;
  logic [31:0]       RetireCnt_o;

  modport master (
    output MemtoReg_i, RegWr_i, WriteAddr_i, ALUOut_i, MemData_i, PCPlus4_i,
    output RsAddr_i, RtAddr_i,
    input  RsData_o, RtData_o, WbData_o, WbEn_o, RetireCnt_o
  );

  modport slave (
    input  MemtoReg_i, RegWr_i, WriteAddr_i, ALUOut_i, MemData_i, PCPlus4_i,
    input  RsAddr_i, RtAddr_i,
    output RsData_o, RtData_o, WbData_o, WbEn_o, RetireCnt_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file for the 5-stage
// MIPS pipeline. Selects the write-back value, commits it one edge later,
// serves two write-first bypassed read ports and counts retired writes.
// NREG must equal 2**ADDR_W so every index addresses a real register.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [31:0]       retire_cnt;

  // Register 0 reads as zero; otherwise a matching write this cycle wins
  // over the stored value so ID sees the result being retired right now.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              en,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == '0)
      return '0;
    else if (en && (waddr == addr))
      return wdata;
    else
      return stored;
  endfunction

  // Write-back source select; the reserved encoding yields zero.
  always_comb begin
    wb_data = '0;
    unique case (bus.MemtoReg_i)
      SEL_ALU:  wb_data = bus.ALUOut_i;
      SEL_MEM:  wb_data = bus.MemData_i;
      SEL_LINK: wb_data = bus.PCPlus4_i;
      SEL_RSVD: wb_data = '0;
      default:  wb_data = '0;
    endcase
  end

  // A write is effective only out of reset, to a non-zero index and with a
  // defined source; this one signal gates commit, bypass and the counter.
  always_comb begin
    wb_en = reset && bus.RegWr_i && (bus.WriteAddr_i != '0) &&
            (bus.MemtoReg_i != SEL_RSVD);
  end

  // Register storage: cleared asynchronously, written one edge after select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[bus.WriteAddr_i] <= wb_data;
    end
  end

  // Retired-write counter for debug; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retire_cnt <= '0;
    else if (wb_en)
      retire_cnt <= retire_cnt + 32'd1;
  end

  // Outputs: combinational read ports and write-back visibility.
  always_comb begin
    bus.WbData_o    = wb_data;
    bus.WbEn_o      = wb_en;
    bus.RetireCnt_o = retire_cnt;
    bus.RsData_o    = read_port(bus.RsAddr_i, regs[bus.RsAddr_i], wb_en,
                                bus.WriteAddr_i, wb_data);
    bus.RtData_o    = read_port(bus.RtAddr_i, regs[bus.RtAddr_i], wb_en,
                                bus.WriteAddr_i, wb_data);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: reset behaviour, write-back select, bypass, register 0,
// reserved select, counter wrap and asynchronous reset clearing.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mtr;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_wb;
    logic        e_en;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] wb;
    logic        en;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] cnt;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] mtr, input logic wr, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.MemtoReg_i  = mtr;
    bus.RegWr_i     = wr;
    bus.WriteAddr_i = wa;
    bus.ALUOut_i    = alu;
    bus.MemData_i   = mem;
    bus.PCPlus4_i   = pc4;
    bus.RsAddr_i    = rs;
    bus.RtAddr_i    = rt;
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " WbData"},    bus.WbData_o,    e.wb);
      check({tag, " WbEn"},      {31'd0, bus.WbEn_o}, {31'd0, e.en});
      check({tag, " RsData"},    bus.RsData_o,    e.rs);
      check({tag, " RtData"},    bus.RtData_o,    e.rt);
      check({tag, " RetireCnt"}, bus.RetireCnt_o, e.cnt);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Main vector table: inputs, then expected outputs sampled before the edge
    // (RetireCnt is the count before this cycle's commit).
    vecs[0] = '{2'd0, 1'b1, 5'd5,  32'h00001234, 32'h0, 32'h0, 5'd5, 5'd0,
                32'h00001234, 1'b1, 32'h00001234, 32'h0, 32'd0};
    vecs[1] = '{2'd1, 1'b1, 5'd6,  32'h0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd6,
                32'hDEADBEEF, 1'b1, 32'h00001234, 32'hDEADBEEF, 32'd1};
    vecs[2] = '{2'd2, 1'b1, 5'd31, 32'h0, 32'h0, 32'h00400008, 5'd6, 5'd31,
                32'h00400008, 1'b1, 32'hDEADBEEF, 32'h00400008, 32'd2};
    vecs[3] = '{2'd0, 1'b0, 5'd5,  32'h00000055, 32'h0, 32'h0, 5'd31, 5'd5,
                32'h00000055, 1'b0, 32'h00400008, 32'h00001234, 32'd3};
    vecs[4] = '{2'd0, 1'b1, 5'd7,  32'hCAFEF00D, 32'h0, 32'h0, 5'd7, 5'd7,
                32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'd3};
    vecs[5] = '{2'd0, 1'b0, 5'd7,  32'h11111111, 32'h0, 32'h0, 5'd7, 5'd7,
                32'h11111111, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 32'd4};
    vecs[6] = '{2'd0, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0,
                32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'd4};
    vecs[7] = '{2'd1, 1'b1, 5'd9,  32'h0, 32'h00009999, 32'h0, 5'd7, 5'd9,
                32'h00009999, 1'b1, 32'hCAFEF00D, 32'h00009999, 32'd4};
    vecs[8] = '{2'd3, 1'b1, 5'd9,  32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 5'd9, 5'd9,
                32'h0, 1'b0, 32'h00009999, 32'h00009999, 32'd5};
    vecs[9] = '{2'd0, 1'b0, 5'd0,  32'h0, 32'h0, 32'h0, 5'd0, 5'd9,
                32'h0, 1'b0, 32'h0, 32'h00009999, 32'd5};

    // Reset held low with a write presented: nothing commits, reads stay zero.
    drive(2'd0, 1'b1, 5'd5, $urandom, $urandom, $urandom, 5'd5, 5'd5);
    @(negedge clk);
    #1;
    check("rst WbEn", {31'd0, bus.WbEn_o}, 32'd0);
    check("rst RsData", bus.RsData_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.ALUOut_i = $urandom;
    @(posedge clk);
    #1;
    check("rst RsData after edge", bus.RsData_o, 32'd0);
    check("rst RetireCnt", bus.RetireCnt_o, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check($sformatf("post-rst Rs r%0d", i), bus.RsData_o, 32'd0);
      check($sformatf("post-rst Rt r%0d", 31 - i), bus.RtData_o, 32'd0);
      @(negedge clk);
    end

    // Table-driven main sequence.
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].mtr, vecs[k].wr, vecs[k].wa, vecs[k].alu, vecs[k].mem,
            vecs[k].pc4, vecs[k].rs, vecs[k].rt);
      sb.push_back('{vecs[k].e_wb, vecs[k].e_en, vecs[k].e_rs, vecs[k].e_rt, vecs[k].e_cnt});
      #1;
      compare_front($sformatf("vec%0d", k));
      @(negedge clk);
    end
    check("retire after table", bus.RetireCnt_o, 32'd5);

    // Counter wrap: preload near the top, then two valid writes.
    force dut.retire_cnt = 32'hFFFFFFFE;
    #1;
    release dut.retire_cnt;
    drive(2'd0, 1'b1, 5'd10, 32'h00000001, 32'h0, 32'h0, 5'd10, 5'd0);
    @(negedge clk);
    check("wrap step1", bus.RetireCnt_o, 32'hFFFFFFFF);
    drive(2'd0, 1'b1, 5'd11, 32'h00000002, 32'h0, 32'h0, 5'd10, 5'd11);
    @(negedge clk);
    check("wrap step2", bus.RetireCnt_o, 32'h00000000);
    check("wrap r10", bus.RsData_o, 32'h00000001);
    check("wrap r11", bus.RtData_o, 32'h00000002);

    // Asynchronous reset between edges clears immediately; the pending write is lost.
    drive(2'd0, 1'b1, 5'd12, 32'h0BADF00D, 32'h0, 32'h0, 5'd10, 5'd11);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async WbEn", {31'd0, bus.WbEn_o}, 32'd0);
    check("async Rs r10", bus.RsData_o, 32'd0);
    check("async Rt r11", bus.RtData_o, 32'd0);
    check("async RetireCnt", bus.RetireCnt_o, 32'd0);
    bus.RegWr_i = 1'b0;
    bus.RsAddr_i = 5'd12;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post-async r12", bus.RsData_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB control bits (MemtoReg, RegWr) together with the MEM/WB datapath fields. It selects the write-back value and commits it to a 32-entry register file. It serves two ID-stage read ports with same-cycle write-to-read bypass and keeps a retired-write counter for debug.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register index width
NREG, 32, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears state immediately)
MemtoReg_i  input  2  write-back source select from MEM/WB: 00 ALU result, 01 memory read data, 10 PC+4 (link), 11 reserved
RegWr_i  input  1  register write enable from MEM/WB
WriteAddr_i  input  ADDR_W  destination register index from MEM/WB
ALUOut_i  input  DATA_W  ALU result from MEM/WB
MemData_i  input  DATA_W  load data from MEM/WB
PCPlus4_i  input  DATA_W  link address from MEM/WB
RsAddr_i  input  ADDR_W  read port A index (ID stage)
RtAddr_i  input  ADDR_W  read port B index (ID stage)
RsData_o  output  DATA_W  read port A data
RtData_o  output  DATA_W  read port B data
WbData_o  output  DATA_W  selected write-back value (combinational, to EX forwarding unit)
WbEn_o  output  1  effective write this cycle (combinational)
RetireCnt_o  output  32  count of committed register writes

Behaviour:
- Clock is clk. Reset is asynchronous, active-low. Asserting reset low forces all NREG registers to 0 and RetireCnt_o to 0 without waiting for a clock edge. Deassertion takes effect at the next rising clk.
- Write-back mux (combinational): WbData_o is selected by MemtoReg_i.
  - 00 gives ALUOut_i.
  - 01 gives MemData_i.
  - 10 gives PCPlus4_i.
  - 11 gives 0.
- WbEn_o = RegWr_i AND (WriteAddr_i != 0) AND (MemtoReg_i != 11). It is 0 while reset is low.
- Commit: on a rising clk with reset high and WbEn_o=1, regs[WriteAddr_i] <= WbData_o. Latency is 1 cycle to storage.
- Register 0 is hardwired zero. Writes to it are discarded, and reads of index 0 always return 0, including via bypass.
- MemtoReg_i=11 is reserved. It suppresses the write even when RegWr_i=1 and does not increment RetireCnt_o.
- Read ports are combinational.
  - RsData_o = 0 if RsAddr_i==0.
  - Otherwise RsData_o = WbData_o if WbEn_o and WriteAddr_i==RsAddr_i (write-first bypass).
  - Otherwise RsData_o = regs[RsAddr_i].
  - RtData_o uses the same rule with RtAddr_i.
  - Both ports may bypass the same write simultaneously.
- RetireCnt_o increments by 1 on every rising clk where WbEn_o=1. It wraps from 0xFFFFFFFF to 0 with no flag. It holds otherwise.
- Reset mid-operation: a write presented in the same cycle reset is low is lost. Registers read 0 and RetireCnt_o reads 0 until the first post-reset commit.
- No stall or flush inputs exist. Bubbles arrive from MEM/WB as RegWr_i=0.

Test Plan:
1. Hold reset low, drive RegWr_i=1 with random data, pulse clk -> all reads return 0, RetireCnt_o=0. Release reset, then read all 32 indices -> all 0.
2. Set MemtoReg_i=00, ALUOut_i=0x1234, WriteAddr_i=5, RegWr_i=1, and one clk -> regs[5]=0x1234, RetireCnt_o=1. Repeat with 01/MemData_i=0xDEADBEEF to reg 6 and 10/PCPlus4_i=0x00400008 to reg 31 -> each read back exactly, counter=3.
3. Bypass: in the same cycle as a write of 0xCAFEF00D to reg 7, set RsAddr_i=RtAddr_i=7 -> both outputs show 0xCAFEF00D before the edge. With RegWr_i=0 on that cycle -> both show the old regs[7].
4. Write 0xFFFFFFFF to reg 0 with RsAddr_i=0 -> RsData_o=0 combinationally and after the edge, WbEn_o=0, counter unchanged.
5. Set MemtoReg_i=11, RegWr_i=1, WriteAddr_i=9 -> WbEn_o=0, WbData_o=0, regs[9] unchanged, counter unchanged.
6. Force RetireCnt_o near wrap (0xFFFFFFFE via 2^32-2 commits, or a bench force/deposit), then two valid writes -> 0xFFFFFFFF then 0x00000000. Drop reset low asynchronously between clk edges -> outputs clear immediately.
